// File: rtl/shadow_contract_checker.sv
// shadow_contract_checker: relational shadow logic for a two-copy out-of-order core.
// Records per-ROB-entry contract observations for both copies, compares them when the
// copies commit, re-aligns the copies by stalling whichever commits alone, and after a
// deviation follows each copy's ROB drain up to the tail captured at that moment.
module shadow_contract_checker #(
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 40,
    parameter int CONTRACT  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             enq_valid,
    input  logic [1:0]             enq_is_br,
    input  logic [1:0]             enq_is_jalr,
    input  logic [1:0]             exe_valid,
    input  logic [3:0]             exe_kind,
    input  logic [2*ROB_IDX_W-1:0] exe_idx,
    input  logic [2*DATA_W-1:0]    exe_rs1,
    input  logic [2*DATA_W-1:0]    exe_rs2,
    input  logic [2*ADDR_W-1:0]    exe_addr,
    input  logic [1:0]             commit_valid,
    input  logic [2*ROB_IDX_W-1:0] rob_head,
    input  logic [2*ROB_IDX_W-1:0] rob_tail,
    input  logic [2*ROB_IDX_W-1:0] rob_next_tail,
    input  logic [2*DATA_W-1:0]    head_wdata,
    input  logic [1:0]             dmem_valid,
    input  logic [2*ADDR_W-1:0]    dmem_addr,
    output logic [1:0]             stall,
    output logic                   commit_dev,
    output logic                   addr_dev,
    output logic                   invalid_program,
    output logic [1:0]             finish,
    output logic                   done
);
    localparam int ROB_DEPTH = 2 ** ROB_IDX_W;
    localparam logic [1:0] KIND_BR     = 2'd0;
    localparam logic [1:0] KIND_MULDIV = 2'd1;
    localparam logic [1:0] KIND_MEM    = 2'd2;

    typedef logic [ROB_IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {LOCKSTEP, STALL_0, STALL_1} state_t;

    // Per-copy views of the packed buses; element c is copy c (0 = copy 1).
    logic [1:0][ROB_IDX_W-1:0] headIdx, tailIdx, nextTailIdx, exeIdx;
    logic [1:0][1:0]           exeKind;
    logic [1:0][DATA_W-1:0]    rs1In, rs2In, wdataIn;
    logic [1:0][ADDR_W-1:0]    addrIn, dmemAddrIn;

    assign headIdx     = rob_head;
    assign tailIdx     = rob_tail;
    assign nextTailIdx = rob_next_tail;
    assign exeIdx      = exe_idx;
    assign exeKind     = exe_kind;
    assign rs1In       = exe_rs1;
    assign rs2In       = exe_rs2;
    assign wdataIn     = head_wdata;
    assign addrIn      = exe_addr;
    assign dmemAddrIn  = dmem_addr;

    // Per-entry observation type bits and recorded operands for each copy.
    logic [1:0][ROB_DEPTH-1:0] isBr_q, isJalr_q, isMulDiv_q, isMem_q;
    logic [DATA_W-1:0]         rs1Mem_q  [2][ROB_DEPTH];
    logic [DATA_W-1:0]         rs2Mem_q  [2][ROB_DEPTH];
    logic [ADDR_W-1:0]         addrMem_q [2][ROB_DEPTH];

    // Commit alignment and sticky flags.
    state_t     state_q;
    logic [1:0] stall_q;
    logic       commitDev_q, addrDev_q, invalidProgram_q;

    // Drain tracking.
    logic [1:0][ROB_IDX_W-1:0] recTail_q, recTail_d;
    logic                      recorded_q, recorded_d;
    logic [1:0]                finish_q, finish_d;
    logic                      done_q;
    logic [1:0][ROB_IDX_W-1:0] tailAge, nextAge;

    // Observations at each copy's own head.
    logic [1:0][DATA_W-1:0] headRs1, headRs2;
    logic [1:0][ADDR_W-1:0] headAddr;
    logic rs1Diff, rs2Diff, addrDiff, ctDev, isaDev, devAny;

    for (genvar g = 0; g < 2; g++) begin : gCopy
        assign headRs1[g]  = rs1Mem_q[g][headIdx[g]];
        assign headRs2[g]  = rs2Mem_q[g][headIdx[g]];
        assign headAddr[g] = addrMem_q[g][headIdx[g]];
        assign tailAge[g]  = recTail_q[g] - headIdx[g];
        assign nextAge[g]  = nextTailIdx[g] - headIdx[g];
    end

    assign rs1Diff  = headRs1[0] != headRs1[1];
    assign rs2Diff  = headRs2[0] != headRs2[1];
    assign addrDiff = headAddr[0] != headAddr[1];

    // Copy 1's type bits decide which observation is contract-relevant for this commit.
    assign ctDev = ((isBr_q[0][headIdx[0]] | isMulDiv_q[0][headIdx[0]]) & (rs1Diff | rs2Diff))
                 | (isJalr_q[0][headIdx[0]] & rs1Diff)
                 | (isMem_q[0][headIdx[0]] & addrDiff);
    assign isaDev = (CONTRACT == 0) ? (wdataIn[0] != wdataIn[1]) : ctDev;
    assign devAny = commitDev_q | addrDev_q;

    // Type bits: enqueue seeds an entry, a same-cycle issue to the same slot overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            isBr_q     <= '0;
            isJalr_q   <= '0;
            isMulDiv_q <= '0;
            isMem_q    <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (enq_valid[c]) begin
                    isBr_q[c][tailIdx[c]]     <= enq_is_br[c];
                    isJalr_q[c][tailIdx[c]]   <= enq_is_jalr[c];
                    isMulDiv_q[c][tailIdx[c]] <= 1'b0;
                    isMem_q[c][tailIdx[c]]    <= 1'b0;
                end
                if (exe_valid[c] && exeKind[c] == KIND_MULDIV) begin
                    isMulDiv_q[c][exeIdx[c]] <= 1'b1;
                end
                if (exe_valid[c] && exeKind[c] == KIND_MEM) begin
                    isMem_q[c][exeIdx[c]] <= 1'b1;
                end
            end
        end
    end

    // Operand/address capture at issue; pure data, only read when a type bit says it matters.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (exe_valid[c] && (exeKind[c] == KIND_BR || exeKind[c] == KIND_MULDIV)) begin
                rs1Mem_q[c][exeIdx[c]] <= rs1In[c];
                rs2Mem_q[c][exeIdx[c]] <= rs2In[c];
            end
            if (exe_valid[c] && exeKind[c] == KIND_MEM) begin
                addrMem_q[c][exeIdx[c]] <= addrIn[c];
            end
        end
    end

    // Commit alignment: a lone commit stalls that copy until the other catches up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= LOCKSTEP;
            stall_q          <= 2'b00;
            commitDev_q      <= 1'b0;
            invalidProgram_q <= 1'b0;
        end else begin
            case (state_q)
                LOCKSTEP: begin
                    if (commit_valid == 2'b11) begin
                        if (isaDev) invalidProgram_q <= 1'b1;
                    end else if (commit_valid == 2'b01) begin
                        state_q     <= STALL_0;
                        stall_q     <= 2'b01;
                        commitDev_q <= 1'b1;
                    end else if (commit_valid == 2'b10) begin
                        state_q     <= STALL_1;
                        stall_q     <= 2'b10;
                        commitDev_q <= 1'b1;
                    end
                end
                STALL_0: begin
                    if (commit_valid[1]) begin
                        if (isaDev) invalidProgram_q <= 1'b1;
                        state_q <= LOCKSTEP;
                        stall_q <= 2'b00;
                    end
                end
                STALL_1: begin
                    if (commit_valid[0]) begin
                        if (isaDev) invalidProgram_q <= 1'b1;
                        state_q <= LOCKSTEP;
                        stall_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= LOCKSTEP;
                    stall_q <= 2'b00;
                end
            endcase
        end
    end

    // Address deviations only count while commit timing has not already diverged.
    always_ff @(posedge clk) begin
        if (rst) begin
            addrDev_q <= 1'b0;
        end else if (!commitDev_q && dmem_valid == 2'b11 && dmemAddrIn[0] != dmemAddrIn[1]) begin
            addrDev_q <= 1'b1;
        end
    end

    // Tail capture, wrap-safe rollback by age relative to head, and sticky drain detection.
    always_comb begin
        recTail_d  = recTail_q;
        recorded_d = recorded_q;
        finish_d   = finish_q;
        for (int c = 0; c < 2; c++) begin
            if (!recorded_q) begin
                if (devAny) recTail_d[c] = tailIdx[c];
            end else begin
                if (nextAge[c] < tailAge[c]) recTail_d[c] = nextTailIdx[c];
                if (tailAge[c] == '0 || (commit_valid[c] && tailAge[c] == idx_t'(1))) begin
                    finish_d[c] = 1'b1;
                end
            end
        end
        if (devAny) recorded_d = 1'b1;
    end

    // Register drain-tracking state and the combined done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            recTail_q  <= '0;
            recorded_q <= 1'b0;
            finish_q   <= 2'b00;
            done_q     <= 1'b0;
        end else begin
            recTail_q  <= recTail_d;
            recorded_q <= recorded_d;
            finish_q   <= finish_d;
            done_q     <= &finish_d;
        end
    end

    assign stall           = stall_q;
    assign commit_dev      = commitDev_q;
    assign addr_dev        = addrDev_q;
    assign invalid_program = invalidProgram_q;
    assign finish          = finish_q;
    assign done            = done_q;
endmodule

// File: tb/tb_shadow_contract_checker.sv
// Self-checking bench for shadow_contract_checker: a cycle-level reference model of the
// checking rules plus directed scenarios with hand-computed literal expectations.
module tb_shadow_contract_checker;
    logic clk = 1'b0;
    logic rst;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    logic [1:0]      enqValid, enqIsBr, enqIsJalr, exeValid, commitValid, dmemValid;
    logic [1:0][1:0] exeKind;
    logic [1:0][4:0] exeIdx, robHead, robTail, robNextTail;
    logic [1:0][63:0] exeRs1, exeRs2, headWdata;
    logic [1:0][39:0] exeAddr, dmemAddr;

    logic [1:0] stall, finish, stallSb, finishSb;
    logic commitDev, addrDev, invalidProgram, done;
    logic commitDevSb, addrDevSb, invalidProgramSb, doneSb;

    shadow_contract_checker #(.ROB_IDX_W(5), .DATA_W(64), .ADDR_W(40), .CONTRACT(1)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enqValid), .enq_is_br(enqIsBr), .enq_is_jalr(enqIsJalr),
        .exe_valid(exeValid), .exe_kind(exeKind), .exe_idx(exeIdx),
        .exe_rs1(exeRs1), .exe_rs2(exeRs2), .exe_addr(exeAddr),
        .commit_valid(commitValid), .rob_head(robHead), .rob_tail(robTail),
        .rob_next_tail(robNextTail), .head_wdata(headWdata),
        .dmem_valid(dmemValid), .dmem_addr(dmemAddr),
        .stall(stall), .commit_dev(commitDev), .addr_dev(addrDev),
        .invalid_program(invalidProgram), .finish(finish), .done(done)
    );

    shadow_contract_checker #(.ROB_IDX_W(5), .DATA_W(64), .ADDR_W(40), .CONTRACT(0)) dutSb (
        .clk(clk), .rst(rst),
        .enq_valid(enqValid), .enq_is_br(enqIsBr), .enq_is_jalr(enqIsJalr),
        .exe_valid(exeValid), .exe_kind(exeKind), .exe_idx(exeIdx),
        .exe_rs1(exeRs1), .exe_rs2(exeRs2), .exe_addr(exeAddr),
        .commit_valid(commitValid), .rob_head(robHead), .rob_tail(robTail),
        .rob_next_tail(robNextTail), .head_wdata(headWdata),
        .dmem_valid(dmemValid), .dmem_addr(dmemAddr),
        .stall(stallSb), .commit_dev(commitDevSb), .addr_dev(addrDevSb),
        .invalid_program(invalidProgramSb), .finish(finishSb), .done(doneSb)
    );

    typedef struct packed {
        bit          br;
        bit          jalr;
        bit          md;
        bit          mem;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [39:0] addr;
    } entry_t;

    entry_t     ent [2][32];
    int         aheadCopy = -1;
    bit         mCommitDev, mAddrDev, mInvCt, mInvSb, mRecorded, mDone;
    bit [1:0]   mFinish;
    logic [4:0] mRec [2];
    bit         modelLive = 1'b0;
    int         checks = 0;
    int         errors = 0;

    function automatic int age(input logic [4:0] x, input logic [4:0] h);
        return (int'(x) - int'(h) + 32) % 32;
    endfunction

    // Constant-time rule: what copy 1 observed at its head must match copy 2's head.
    function automatic bit ctDeviates();
        entry_t a, b;
        a = ent[0][robHead[0]];
        b = ent[1][robHead[1]];
        if ((a.br || a.md) && (a.rs1 != b.rs1 || a.rs2 != b.rs2)) return 1'b1;
        if (a.jalr && a.rs1 != b.rs1) return 1'b1;
        if (a.mem && a.addr != b.addr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        enqValid = '0; enqIsBr = '0; enqIsJalr = '0; exeValid = '0; exeKind = '0; exeIdx = '0;
        exeRs1 = '0; exeRs2 = '0; exeAddr = '0; commitValid = '0; robHead = '0; robTail = '0;
        robNextTail = '0; headWdata = '0; dmemValid = '0; dmemAddr = '0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
    endtask

    task automatic setHeads(input int h0, input int h1);
        robHead[0] = 5'(h0);
        robHead[1] = 5'(h1);
    endtask

    task automatic setTails(input int t, input int nt);
        robTail[0] = 5'(t); robTail[1] = 5'(t);
        robNextTail[0] = 5'(nt); robNextTail[1] = 5'(nt);
    endtask

    task automatic issueBoth(input int kind, input int idx, input logic [63:0] a1, input logic [63:0] b1,
                             input logic [63:0] a2, input logic [63:0] b2);
        exeValid = 2'b11;
        exeKind[0] = 2'(kind); exeKind[1] = 2'(kind);
        exeIdx[0] = 5'(idx); exeIdx[1] = 5'(idx);
        exeRs1[0] = a1; exeRs1[1] = b1;
        exeRs2[0] = a2; exeRs2[1] = b2;
        exeAddr[0] = a1[39:0]; exeAddr[1] = b1[39:0];
    endtask

    // Reference model: applies the checking rules to the inputs sampled at each rising edge.
    always @(posedge clk) begin : model
        bit devCt, devSb, oldDev, oldRecorded, oldCommitDev;
        logic [4:0] oldRec [2];
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                for (int e = 0; e < 32; e++) begin
                    ent[c][e].br = 0; ent[c][e].jalr = 0; ent[c][e].md = 0; ent[c][e].mem = 0;
                end
                mRec[c] = '0;
            end
            aheadCopy = -1;
            mCommitDev = 0; mAddrDev = 0; mInvCt = 0; mInvSb = 0; mRecorded = 0; mFinish = 0; mDone = 0;
            modelLive = 1'b1;
        end else begin
            devCt = ctDeviates();
            devSb = headWdata[0] != headWdata[1];
            oldCommitDev = mCommitDev;
            oldDev = mCommitDev | mAddrDev;
            oldRecorded = mRecorded;
            oldRec[0] = mRec[0]; oldRec[1] = mRec[1];
            if (!oldCommitDev && dmemValid == 2'b11 && dmemAddr[0] != dmemAddr[1]) mAddrDev = 1;
            if (aheadCopy < 0) begin
                if (commitValid == 2'b11) begin
                    mInvCt |= devCt; mInvSb |= devSb;
                end else if (commitValid != 2'b00) begin
                    aheadCopy = commitValid[0] ? 0 : 1;
                    mCommitDev = 1;
                end
            end else if (commitValid[1 - aheadCopy]) begin
                mInvCt |= devCt; mInvSb |= devSb;
                aheadCopy = -1;
            end
            for (int c = 0; c < 2; c++) begin
                if (oldRecorded) begin
                    if (age(oldRec[c], robHead[c]) == 0 ||
                        (commitValid[c] && age(oldRec[c], robHead[c]) == 1)) mFinish[c] = 1;
                    if (age(robNextTail[c], robHead[c]) < age(oldRec[c], robHead[c])) mRec[c] = robNextTail[c];
                end else if (oldDev) begin
                    mRec[c] = robTail[c];
                end
            end
            if (oldDev) mRecorded = 1;
            mDone = mFinish[0] & mFinish[1];
            for (int c = 0; c < 2; c++) begin
                if (enqValid[c]) begin
                    ent[c][robTail[c]].br = enqIsBr[c];
                    ent[c][robTail[c]].jalr = enqIsJalr[c];
                    ent[c][robTail[c]].md = 0;
                    ent[c][robTail[c]].mem = 0;
                end
                if (exeValid[c]) begin
                    if (exeKind[c] == 2'd0 || exeKind[c] == 2'd1) begin
                        ent[c][exeIdx[c]].rs1 = exeRs1[c];
                        ent[c][exeIdx[c]].rs2 = exeRs2[c];
                    end
                    if (exeKind[c] == 2'd1) ent[c][exeIdx[c]].md = 1;
                    if (exeKind[c] == 2'd2) begin
                        ent[c][exeIdx[c]].addr = exeAddr[c];
                        ent[c][exeIdx[c]].mem = 1;
                    end
                end
            end
        end
    end

    // Compare every output against the model on the falling edge, once the model is live.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("model_stall", {62'b0, stall},
                        (aheadCopy < 0) ? 64'd0 : ((aheadCopy == 0) ? 64'd1 : 64'd2));
            checkOutput("model_commit_dev", {63'b0, commitDev}, {63'b0, mCommitDev});
            checkOutput("model_addr_dev", {63'b0, addrDev}, {63'b0, mAddrDev});
            checkOutput("model_invalid_ct", {63'b0, invalidProgram}, {63'b0, mInvCt});
            checkOutput("model_invalid_sb", {63'b0, invalidProgramSb}, {63'b0, mInvSb});
            checkOutput("model_finish", {62'b0, finish}, {62'b0, mFinish});
            checkOutput("model_done", {63'b0, done}, {63'b0, mDone});
        end
    end

    // Hang guard.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios with literal expectations.
    initial begin
        clearInputs();
        rst = 1'b1;
        applyStimulus(2);
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_flags", {commitDev, addrDev, invalidProgram}, 0);
        checkOutput("reset_finish_done", {finish, done}, 0);
        rst = 1'b0;

        // Identical lockstep streams with branches enqueued and issued alike.
        for (int i = 0; i < 10; i++) begin
            commitValid = 2'b11;
            setHeads(i, i);
            setTails(i + 4, i + 5);
            enqValid = 2'b11; enqIsBr = 2'b11;
            issueBoth(0, i + 2, 64'(i), 64'(i), 64'(i * 3), 64'(i * 3));
            applyStimulus(1);
            checkOutput("lockstep_stall", stall, 0);
            checkOutput("lockstep_flags", {commitDev, addrDev, invalidProgram, invalidProgramSb}, 0);
        end

        // Copy 1 commits alone, copy 2 catches up two cycles later.
        doReset();
        setHeads(20, 20);
        commitValid = 2'b01;
        applyStimulus(1);
        checkOutput("timing_stall_c6", stall, 2'b01);
        checkOutput("timing_commit_dev_c6", commitDev, 1);
        commitValid = 2'b00;
        dmemValid = 2'b11; dmemAddr[0] = 40'h100; dmemAddr[1] = 40'h200;
        applyStimulus(1);
        checkOutput("timing_stall_c7", stall, 2'b01);
        checkOutput("timing_addr_dev_masked", addrDev, 0);
        dmemValid = 2'b00;
        commitValid = 2'b10;
        applyStimulus(1);
        checkOutput("timing_stall_c8", stall, 2'b00);
        checkOutput("timing_commit_dev_sticky", commitDev, 1);
        commitValid = 2'b00;
        applyStimulus(1);

        // Branch operand differs: CT flags it, sandbox with equal wdata does not.
        doReset();
        setTails(3, 4);
        enqValid = 2'b11; enqIsBr = 2'b11;
        applyStimulus(1);
        enqValid = 2'b00; enqIsBr = 2'b00;
        issueBoth(0, 3, 64'h10, 64'h11, 64'h5, 64'h5);
        applyStimulus(1);
        exeValid = 2'b00;
        commitValid = 2'b11; setHeads(3, 3);
        headWdata[0] = 64'h77; headWdata[1] = 64'h77;
        applyStimulus(1);
        checkOutput("ct_branch_invalid", invalidProgram, 1);
        checkOutput("sb_equal_wdata", invalidProgramSb, 0);
        checkOutput("ct_branch_no_commit_dev", commitDev, 0);
        setHeads(4, 4);
        headWdata[0] = 64'h1; headWdata[1] = 64'h2;
        applyStimulus(1);
        checkOutput("sb_wdata_differs", invalidProgramSb, 1);
        commitValid = 2'b00; headWdata = '0;

        // jalr compares rs1 only; then a same-cycle enqueue+muldiv issue keeps the muldiv type.
        doReset();
        setTails(6, 7);
        enqValid = 2'b11; enqIsJalr = 2'b11;
        applyStimulus(1);
        enqValid = 2'b00; enqIsJalr = 2'b00;
        issueBoth(0, 6, 64'h7, 64'h7, 64'h1, 64'h2);
        applyStimulus(1);
        exeValid = 2'b00;
        commitValid = 2'b11; setHeads(6, 6);
        applyStimulus(1);
        checkOutput("jalr_rs2_ignored", invalidProgram, 0);
        commitValid = 2'b00;
        setTails(8, 9);
        enqValid = 2'b11;
        issueBoth(1, 8, 64'h4, 64'h9, 64'h0, 64'h0);
        applyStimulus(1);
        enqValid = 2'b00; exeValid = 2'b00;
        commitValid = 2'b11; setHeads(8, 8);
        applyStimulus(1);
        checkOutput("muldiv_issue_wins", invalidProgram, 1);
        commitValid = 2'b00;

        // Memory observation with differing addresses.
        doReset();
        setTails(9, 10);
        enqValid = 2'b11;
        applyStimulus(1);
        enqValid = 2'b00;
        issueBoth(2, 9, 64'h100, 64'h108, 64'h0, 64'h0);
        applyStimulus(1);
        exeValid = 2'b00;
        commitValid = 2'b11; setHeads(9, 9);
        applyStimulus(1);
        checkOutput("mem_addr_invalid", invalidProgram, 1);
        commitValid = 2'b00;

        // Address deviation at tail 30; a numerically smaller next tail is not a rollback.
        doReset();
        setTails(30, 30); setHeads(26, 26);
        dmemValid = 2'b11; dmemAddr[0] = 40'h8000; dmemAddr[1] = 40'h8040;
        applyStimulus(1);
        checkOutput("addr_dev_set", addrDev, 1);
        checkOutput("addr_dev_no_commit_dev", commitDev, 0);
        dmemValid = 2'b00;
        setTails(30, 2);
        applyStimulus(1);
        for (int h = 27; h <= 29; h++) begin
            setHeads(h, h);
            applyStimulus(1);
            checkOutput("tail30_no_early_finish", finish, 0);
        end
        setHeads(30, 29);
        applyStimulus(1);
        checkOutput("tail30_finish_copy1", finish, 2'b01);
        checkOutput("tail30_not_done", done, 0);
        commitValid = 2'b11;
        applyStimulus(1);
        checkOutput("tail30_finish_both", finish, 2'b11);
        checkOutput("tail30_done", done, 1);
        commitValid = 2'b00;

        // Recorded tail 2 with head wrapping 30 -> 31 -> 0 -> 1 -> 2.
        doReset();
        setTails(2, 2); setHeads(30, 30);
        dmemValid = 2'b11; dmemAddr[0] = 40'h8000; dmemAddr[1] = 40'h8040;
        applyStimulus(1);
        dmemValid = 2'b00;
        applyStimulus(1);
        for (int h = 31; h <= 33; h++) begin
            setHeads(h % 32, h % 32);
            applyStimulus(1);
            checkOutput("wrap_no_early_finish", finish, 0);
        end
        setHeads(2, 2);
        applyStimulus(1);
        checkOutput("wrap_finish", finish, 2'b11);

        // Rollback: recorded tail 12 pulled back to 10 by a younger-first next tail.
        doReset();
        setTails(12, 12); setHeads(8, 8);
        dmemValid = 2'b11; dmemAddr[0] = 40'h1; dmemAddr[1] = 40'h2;
        applyStimulus(1);
        dmemValid = 2'b00;
        applyStimulus(1);
        setTails(12, 10);
        applyStimulus(1);
        setHeads(9, 9);
        applyStimulus(1);
        checkOutput("rollback_head9_no_finish", finish, 0);
        setHeads(10, 10);
        applyStimulus(1);
        checkOutput("rollback_head10_finish", finish, 2'b11);

        // Simultaneous commit and address deviation, then reset while copy 2 is stalled.
        doReset();
        commitValid = 2'b10;
        dmemValid = 2'b11; dmemAddr[0] = 40'h40; dmemAddr[1] = 40'h80;
        applyStimulus(1);
        checkOutput("simul_stall", stall, 2'b10);
        checkOutput("simul_both_devs", {commitDev, addrDev}, 2'b11);
        commitValid = 2'b00; dmemValid = 2'b00;
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("midreset_stall", stall, 0);
        checkOutput("midreset_flags", {commitDev, addrDev, invalidProgram}, 0);
        checkOutput("midreset_finish_done", {finish, done}, 0);
        rst = 1'b0;
        applyStimulus(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
